shift_sub_divider: RTL and testbench
====================================

// Module: shift_sub_divider
// PURPOSE
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   Inverse counterpart of the shift-add multiplier datapath:
//     shift-left/subtract instead of add/shift-right.
//   Contains the FSM controller and the {remainder, quotient} working register.
//   Used by the arithmetic unit alongside the multiplier, with the same start/done style.
// PARAMETERS
//   WIDTH   4   operand width; dividend, divisor, quotient and remainder are WIDTH bits
// PORTS
//   clk          in   1      clock, rising edge
//   n_reset      in   1      reset, asynchronous, active-low
//   start        in   1      request; sampled only in IDLE
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   busy         out  1      high in CALC and DONE
//   done         out  1      one-cycle pulse: result valid
//   quotient     out  WIDTH  result, held until next result
//   remainder    out  WIDTH  result, held until next result
//   div_by_zero  out  1      set with the result when divisor==0; held like the result
// BEHAVIOUR
//   Reset: state=IDLE; work reg, divisor reg and count = 0;
//     busy=done=div_by_zero=0; quotient=remainder=0.
//     Reset mid-operation aborts immediately. No result and no done pulse are produced.
//   FSM states (div_pkg::state_t): IDLE, CALC, DONE.
//   IDLE, start=1, divisor!=0:
//     work <= {(WIDTH+1)'0, dividend}; dreg <= divisor; count <= WIDTH; go to CALC.
//   IDLE, start=1, divisor==0: go to DONE directly. Result on that same edge:
//     quotient <= all ones; remainder <= dividend; div_by_zero <= 1.
//   CALC, every edge:
//     s = work << 1;  diff = s[2W:W] - {1'b0, dreg}   (both WIDTH+1 bits)
//     diff non-negative (no borrow): work <= {diff, s[W-1:1], 1'b1}
//     otherwise:                     work <= s   (LSB 0)
//     count <= count - 1. When count==1 on this edge, go to DONE and, on the same edge:
//       quotient <= new work[W-1:0]; remainder <= new work[2W-1:W]; div_by_zero <= 0.
//   DONE: done=1 for exactly one cycle, then IDLE.
//   Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH.
//     Divide-by-zero: done high in the cycle after edge k.
//   start while busy (CALC or DONE) is ignored. No queuing. Operand changes while busy are ignored.
//   Remainder upper bit (work[2W]) is always 0 after a CALC step; only WIDTH bits are exported.
//   Outputs are registered. quotient/remainder/div_by_zero change only on the result edge and on reset.
//   count is $clog2(WIDTH+1) bits wide. WIDTH=1 must work (one CALC cycle).
// STRUCTURE
//   div_pkg: state_t enum {IDLE, CALC, DONE}; localparam helper CNT_W(WIDTH).
//   Sub-module div_regs: the 2*WIDTH+1 working register plus divisor register.
//     Controls: LOAD, STEP.
//     Mirror of the multiplier's register block: shift-left/subtract vs add/shift-right.
//   Top level: FSM, counter, result/flag registers.
// TESTING (WIDTH=4)
//   13/3, start 1 cycle -> done 5th cycle after start edge; q=4, r=1, dbz=0; busy high 4+1 cycles.
//   15/1 -> q=15, r=0.   5/7 -> q=0, r=5.   0/9 -> q=0, r=0.
//   9/0 -> done in cycle after start edge; q=15, r=9, dbz=1. Next 6/2 -> q=3, r=0, dbz=0.
//   12/5 in flight, start pulsed with 7/7 in CALC and in DONE -> only 12/5 result (q=2, r=2).
//     No second done pulse.
//   n_reset low during 2nd CALC cycle of 14/3:
//     all outputs 0 at once, asynchronously; no done pulse.
//     After release, 14/3 -> q=4, r=2.
//   Exhaustive sweep of all 256 operand pairs vs reference model (a/b, a%b, b==0 rule).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the shift/subtract divider.
// Contents: state_t (controller states) and cnt_w() (step counter width).
// Imported by div_regs and shift_sub_divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_w(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_regs.sv
// Working register {remainder, quotient} (2*WIDTH+1 bits) plus divisor register.
// Ports: clk, n_reset; load (capture operands), step (one restoring step);
//        dividend/divisor operands in; step_res = work value after the current step.
module div_regs
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] step_res
);

  logic [2*WIDTH:0]   work;
  logic [2*WIDTH:0]   work_nxt;
  logic [WIDTH-1:0]   dreg;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH+1:0]   diff_ext;

  // One restoring step: shift left, trial-subtract the divisor from the
  // upper WIDTH+1 bits. The extra top bit of diff_ext is the borrow.
  always_comb begin
    shifted  = work << 1;
    diff_ext = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dreg};
    work_nxt = shifted;
    if (!diff_ext[WIDTH+1]) begin
      work_nxt[2*WIDTH:WIDTH] = diff_ext[WIDTH:0];
      // shifted[0] is always 0, so setting it inserts the quotient bit
      // (also valid for WIDTH=1 where no middle bits exist).
      work_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      work <= '0;
      dreg <= '0;
    end else if (load) begin
      work <= {{(WIDTH+1){1'b0}}, dividend};
      dreg <= divisor;
    end else if (step) begin
      work <= work_nxt;
    end
  end

  // The remainder's top bit is always 0 after a step, so it is not exported.
  assign step_res = work_nxt[2*WIDTH-1:0];

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock (start/done handshake).
// Ports: clk, n_reset (async, active-low); start, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out (all registered).
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic                 divisor_zero;
  logic                 load;
  logic                 step;
  logic [2*WIDTH-1:0]   step_res;

  assign divisor_zero = (divisor == '0);
  assign load         = (state == IDLE) && start && !divisor_zero;
  assign step         = (state == CALC);

  div_regs #(.WIDTH(WIDTH)) u_regs (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (load),
    .step     (step),
    .dividend (dividend),
    .divisor  (divisor),
    .step_res (step_res)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor_zero) begin
              // No iteration needed: publish the saturated result right away.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              count <= CNT_W'(WIDTH);
            end
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            // Last step: capture the post-step register contents on this edge.
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= step_res[WIDTH-1:0];
            remainder   <= step_res[2*WIDTH-1:WIDTH];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider (WIDTH=4): directed cases, exhaustive
// sweep and random operands against an arithmetic reference model.
module tb_shift_sub_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q   = W'((1 << W) - 1);
      e.r   = W'(a);
      e.dbz = 1'b1;
    end else begin
      e.q   = W'(a / b);
      e.r   = W'(a % b);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (n_reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", int'(quotient), int'(mon_e.q));
        check("remainder", int'(remainder), int'(mon_e.r));
        check("div_by_zero", int'(div_by_zero), int'(mon_e.dbz));
      end
    end
  end

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_div(input int a, input int b);
    int cycles;
    @(negedge clk);
    check("idle_before_start", int'(busy), 0);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    wait_done(cycles);
    check("latency", cycles, (b == 0) ? 0 : W);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int cycles;
    int a;
    int b;

    // Reset state
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;

    // Directed cases
    run_div(13, 3);
    run_div(15, 1);
    run_div(5, 7);
    run_div(0, 9);
    run_div(9, 0);
    run_div(6, 2);

    // Start requests during CALC and DONE must be ignored
    @(negedge clk);
    check("idle_before_12_5", int'(busy), 0);
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    sb.push_back(model(12, 5));
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 4'd7;
    divisor  = 4'd7;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cycles);
    check("latency_12_5", cycles + 2, W);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_ignored", int'(busy), 0);
    repeat (8) @(negedge clk);
    check("no_restart", int'(busy), 0);

    // Asynchronous reset in the second CALC cycle of 14/3
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_quotient", int'(quotient), 0);
    check("arst_remainder", int'(remainder), 0);
    check("arst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    @(negedge clk);
    check("arst_no_done", int'(done), 0);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_idle", int'(busy), 0);
    run_div(14, 3);

    // Exhaustive sweep
    for (int i = 0; i < 256; i++) begin
      run_div(i / 16, i % 16);
    end

    // Random operands with random idle gaps
    for (int n = 0; n < 60; n++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_div(a, b);
    end

    repeat (6) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
